// File: rtl/lpc_frame_arbiter_if.sv
// lpc_frame_arbiter_if: source streams, encoder input/output handshakes,
// config and status of the LPC frame arbiter, bundled for port use.
interface lpc_frame_arbiter_if #(
   parameter int N_SRC = 4,
   parameter int IDW   = 2
);
   logic [16*N_SRC-1:0] S_DATA;
   logic [N_SRC-1:0]    S_VALID;
   logic [N_SRC-1:0]    S_FLAST;
   logic [N_SRC-1:0]    S_SLAST;
   logic [N_SRC-1:0]    S_READY;
   logic                CFG_ENABLE;
   logic [N_SRC-1:0]    CFG_MASK;
   logic [15:0]         ENC_IN_SOURCE;
   logic                ENC_IN_VALID;
   logic                ENC_T_LAST;
   logic                ENC_SAMPLE_LAST;
   logic                ENC_TUSER;
   logic                ENC_READY;
   logic                ENC_OUT_VALID;
   logic                ENC_T_READY;
   logic [IDW-1:0]      CW_SRC_ID;
   logic                CW_ID_VALID;
   logic                BUSY;
   logic [7:0]          STAT_TIMEOUTS;

   modport master (
      input  S_DATA, S_VALID, S_FLAST, S_SLAST,
      input  CFG_ENABLE, CFG_MASK,
      input  ENC_READY, ENC_OUT_VALID, ENC_T_READY,
      output S_READY,
      output ENC_IN_SOURCE, ENC_IN_VALID, ENC_T_LAST,
      output ENC_SAMPLE_LAST, ENC_TUSER,
      output CW_SRC_ID, CW_ID_VALID, BUSY, STAT_TIMEOUTS
   );

   modport slave (
      output S_DATA, S_VALID, S_FLAST, S_SLAST,
      output CFG_ENABLE, CFG_MASK,
      output ENC_READY, ENC_OUT_VALID, ENC_T_READY,
      input  S_READY,
      input  ENC_IN_SOURCE, ENC_IN_VALID, ENC_T_LAST,
      input  ENC_SAMPLE_LAST, ENC_TUSER,
      input  CW_SRC_ID, CW_ID_VALID, BUSY, STAT_TIMEOUTS
   );
endinterface

// File: rtl/lpc_frame_arbiter.sv
// lpc_frame_arbiter: round-robin sharing of one lpc_encoder between
// N_SRC sample streams, one codeword frame per grant, with pad/flush/tag.
module lpc_frame_arbiter #(
   parameter int N_SRC       = 4,
   parameter int FRAME_BEATS = 4,
   parameter int TIMEOUT     = 64,
   parameter int IDW         = 2
) (
   input logic ACLK,
   input logic ARESET_N,
   lpc_frame_arbiter_if.master bus
);
   localparam int BW = $clog2(FRAME_BEATS + 1);
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0]  LAST_BEAT = BW'(FRAME_BEATS - 1);
   localparam logic [TW-1:0]  TMO_LIM   = TW'(TIMEOUT);
   localparam logic [IDW-1:0] LAST_SRC  = IDW'(N_SRC - 1);

   typedef enum logic [2:0] {
      IDLE,
      XFER,
      PAD,
      WAIT_OUT,
      FLUSH
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [IDW-1:0] r_grant;
   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] r_cw_id;
   logic [BW-1:0]  r_beat;
   logic [TW-1:0]  r_tmo;
   logic [7:0]     r_stat;

   logic [15:0]      w_src_data [N_SRC];
   logic [N_SRC-1:0] w_elig;
   logic             w_found;
   logic [IDW-1:0]   w_win;
   logic [IDW-1:0]   w_cand;
   logic [IDW-1:0]   w_grant_inc;
   logic [TW-1:0]    w_tmo_inc;
   logic             w_tmo_hit;
   logic             w_tlast;
   logic             w_beat;
   logic             w_out_done;
   logic [N_SRC-1:0] w_ready;
   logic             w_in_valid;
   logic [15:0]      w_in_src;
   logic             w_in_slast;
   logic             w_in_tlast;
   logic             w_tuser;

   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign w_src_data[gi] = bus.S_DATA[16*gi +: 16];
   end

   assign w_elig      = bus.S_VALID & bus.CFG_MASK & {N_SRC{bus.CFG_ENABLE}};
   assign w_grant_inc = (r_grant == LAST_SRC) ? '0 : r_grant + 1'b1;
   assign w_tmo_inc   = r_tmo + 1'b1;
   assign w_tmo_hit   = (TIMEOUT != 0) && (w_tmo_inc == TMO_LIM);
   assign w_tlast     = (r_beat == LAST_BEAT);
   assign w_out_done  = bus.ENC_OUT_VALID & bus.ENC_T_READY;

   // Round-robin search: first eligible source at or after the pointer.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_cand = IDW'((int'(r_ptr) + i) % N_SRC);
         if (!w_found && w_elig[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   // Next state and encoder/source handshake outputs.
   always_comb begin
      w_next     = r_state;
      w_ready    = '0;
      w_in_valid = 1'b0;
      w_in_src   = '0;
      w_in_slast = 1'b0;
      w_in_tlast = 1'b0;
      w_tuser    = 1'b0;
      w_beat     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_found) w_next = XFER;
         end
         XFER: begin
            w_in_valid       = bus.S_VALID[r_grant];
            w_in_src         = w_src_data[r_grant];
            w_in_slast       = bus.S_SLAST[r_grant];
            w_in_tlast       = w_tlast;
            w_ready[r_grant] = bus.ENC_READY;
            w_beat           = w_in_valid & bus.ENC_READY;
            if (w_beat) begin
               if (w_tlast) w_next = WAIT_OUT;
               else if (bus.S_FLAST[r_grant]) w_next = PAD;
            end else if (w_tmo_hit) begin
               w_next = FLUSH;
            end
         end
         PAD: begin
            w_in_valid = 1'b1;
            w_in_tlast = w_tlast;
            w_beat     = bus.ENC_READY;
            if (w_beat && w_tlast) w_next = WAIT_OUT;
         end
         WAIT_OUT: begin
            if (w_out_done) w_next = IDLE;
         end
         FLUSH: begin
            w_tuser = 1'b1;
            w_next  = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge ACLK or negedge ARESET_N) begin
      if (!ARESET_N) r_state <= IDLE;
      else           r_state <= w_next;
   end

   // Grant, pointer, beat/idle counters, codeword tag and flush statistic.
   always_ff @(posedge ACLK or negedge ARESET_N) begin
      if (!ARESET_N) begin
         r_grant <= '0;
         r_ptr   <= '0;
         r_cw_id <= '0;
         r_beat  <= '0;
         r_tmo   <= '0;
         r_stat  <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_beat <= '0;
               r_tmo  <= '0;
               if (w_found) r_grant <= w_win;
            end
            XFER: begin
               if (w_beat) begin
                  r_beat <= r_beat + 1'b1;
                  r_tmo  <= '0;
                  if (w_tlast) r_cw_id <= r_grant;
               end else begin
                  r_tmo <= w_tmo_inc;
               end
            end
            PAD: begin
               if (w_beat) begin
                  r_beat <= r_beat + 1'b1;
                  if (w_tlast) r_cw_id <= r_grant;
               end
            end
            WAIT_OUT: begin
               if (w_out_done) begin
                  r_ptr  <= w_grant_inc;
                  r_beat <= '0;
               end
            end
            FLUSH: begin
               r_ptr  <= w_grant_inc;
               r_beat <= '0;
               if (r_stat != 8'hFF) r_stat <= r_stat + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.S_READY         = w_ready;
   assign bus.ENC_IN_VALID    = w_in_valid;
   assign bus.ENC_IN_SOURCE   = w_in_src;
   assign bus.ENC_SAMPLE_LAST = w_in_slast;
   assign bus.ENC_T_LAST      = w_in_tlast;
   assign bus.ENC_TUSER       = w_tuser;
   assign bus.CW_SRC_ID       = r_cw_id;
   assign bus.CW_ID_VALID     = (r_state == WAIT_OUT);
   assign bus.BUSY            = (r_state != IDLE);
   assign bus.STAT_TIMEOUTS   = r_stat;

endmodule

// File: tb/tb_lpc_frame_arbiter.sv
// tb_lpc_frame_arbiter: directed stimulus with a scoreboard of expected
// encoder beats, codeword tags and flush pulses.
module tb_lpc_frame_arbiter;
   localparam int N = 4;

   typedef struct packed {
      logic [15:0] d;
      logic        fl;
      logic        sl;
   } sbeat_t;

   typedef struct packed {
      logic [15:0] d;
      logic        tl;
      logic        sl;
      logic [3:0]  rdy;
   } ebeat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   lpc_frame_arbiter_if #(.N_SRC(N), .IDW(2)) bus ();

   lpc_frame_arbiter #(
      .N_SRC(N), .FRAME_BEATS(4), .TIMEOUT(8), .IDW(2)
   ) dut (
      .ACLK(clk),
      .ARESET_N(rst_n),
      .bus(bus)
   );

   sbeat_t     srcq [N][$];
   ebeat_t     exp_q[$];
   logic [1:0] cw_q[$];
   int         exp_tuser = 0;
   int         n_chk = 0;
   int         n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic src_frame(input int s, input logic [15:0] base,
                            input int n, input logic sl_last);
      for (int k = 0; k < n; k++)
         srcq[s].push_back(sbeat_t'{d: base + 16'(k), fl: 1'b0,
                                    sl: sl_last && (k == 3)});
   endtask

   task automatic exp_frame(input int s, input logic [15:0] base,
                            input logic sl_last);
      for (int k = 0; k < 4; k++)
         exp_q.push_back(ebeat_t'{d: base + 16'(k), tl: (k == 3),
                                  sl: sl_last && (k == 3),
                                  rdy: 4'(1 << s)});
   endtask

   task automatic exp_beat(input logic [15:0] d, input logic tl,
                           input logic [3:0] rdy);
      exp_q.push_back(ebeat_t'{d: d, tl: tl, sl: 1'b0, rdy: rdy});
   endtask

   task automatic check_zero(input string p);
      chk({p, "_in_valid"}, 32'(bus.ENC_IN_VALID), 0);
      chk({p, "_in_source"}, 32'(bus.ENC_IN_SOURCE), 0);
      chk({p, "_s_ready"}, 32'(bus.S_READY), 0);
      chk({p, "_t_last"}, 32'(bus.ENC_T_LAST), 0);
      chk({p, "_sample_last"}, 32'(bus.ENC_SAMPLE_LAST), 0);
      chk({p, "_tuser"}, 32'(bus.ENC_TUSER), 0);
      chk({p, "_cw_src_id"}, 32'(bus.CW_SRC_ID), 0);
      chk({p, "_cw_id_valid"}, 32'(bus.CW_ID_VALID), 0);
      chk({p, "_busy"}, 32'(bus.BUSY), 0);
      chk({p, "_stat"}, 32'(bus.STAT_TIMEOUTS), 0);
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(exp_q.size() == 0 && cw_q.size() == 0 &&
                   !bus.BUSY && !bus.CW_ID_VALID) && n < budget);
      n_chk++;
      if (n < budget) n_pass++;
      else $display("FAIL %s: drain not reached in %0d cycles, %0d beats left",
                    nm, budget, exp_q.size());
      repeat (2) @(negedge clk);
   endtask

   // Source stream drivers: present queue heads, pop on handshake.
   initial begin : p_drv
      logic [N-1:0] fire;
      bus.S_VALID = '0;
      bus.S_DATA  = '0;
      bus.S_FLAST = '0;
      bus.S_SLAST = '0;
      forever begin
         @(negedge clk);
         fire = bus.S_VALID & bus.S_READY;
         @(posedge clk);
         #2;
         for (int i = 0; i < N; i++) begin
            if (fire[i] && rst_n && srcq[i].size() > 0)
               void'(srcq[i].pop_front());
            if (srcq[i].size() > 0) begin
               bus.S_VALID[i]         = 1'b1;
               bus.S_DATA[16*i +: 16] = srcq[i][0].d;
               bus.S_FLAST[i]         = srcq[i][0].fl;
               bus.S_SLAST[i]         = srcq[i][0].sl;
            end else begin
               bus.S_VALID[i]         = 1'b0;
               bus.S_DATA[16*i +: 16] = '0;
               bus.S_FLAST[i]         = 1'b0;
               bus.S_SLAST[i]         = 1'b0;
            end
         end
      end
   end

   // Encoder output side: accept each tagged codeword two cycles later.
   initial begin : p_resp
      bus.ENC_OUT_VALID = 1'b0;
      bus.ENC_T_READY   = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.CW_ID_VALID && rst_n) begin
            @(posedge clk);
            #1;
            bus.ENC_OUT_VALID = 1'b1;
            bus.ENC_T_READY   = 1'b1;
            @(posedge clk);
            #1;
            bus.ENC_OUT_VALID = 1'b0;
            bus.ENC_T_READY   = 1'b0;
            @(negedge clk);
            chk("wait_out_exit_busy", 32'(bus.BUSY), 0);
            chk("wait_out_exit_cw_valid", 32'(bus.CW_ID_VALID), 0);
         end
      end
   end

   // Monitor: compare every encoder beat, tag and flush against the queues.
   initial begin : p_mon
      ebeat_t e;
      logic   prev_cw;
      prev_cw = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.ENC_IN_VALID && bus.ENC_READY) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL beat_unexpected: got data 0x%0h, expected none",
                        bus.ENC_IN_SOURCE);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", 32'(bus.ENC_IN_SOURCE), 32'(e.d));
               chk("beat_t_last", 32'(bus.ENC_T_LAST), 32'(e.tl));
               chk("beat_sample_last", 32'(bus.ENC_SAMPLE_LAST), 32'(e.sl));
               chk("beat_s_ready", 32'(bus.S_READY), 32'(e.rdy));
            end
         end
         if (bus.CW_ID_VALID && !prev_cw) begin
            if (cw_q.size() == 0) begin
               n_chk++;
               $display("FAIL cw_unexpected: got id %0d, expected none",
                        bus.CW_SRC_ID);
            end else begin
               chk("cw_src_id", 32'(bus.CW_SRC_ID), 32'(cw_q.pop_front()));
            end
         end
         prev_cw = bus.CW_ID_VALID;
         if (bus.ENC_TUSER) begin
            n_chk++;
            if (exp_tuser > 0) begin
               exp_tuser--;
               n_pass++;
            end else begin
               $display("FAIL tuser_unexpected: got pulse, expected none");
            end
         end
      end
   end

   initial begin : p_wdog
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : p_main
      int n;
      bus.CFG_ENABLE = 1'b0;
      bus.CFG_MASK   = '0;
      bus.ENC_READY  = 1'b1;
      #1 rst_n = 1'b0;
      #2 check_zero("rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n          = 1'b1;
      bus.CFG_ENABLE = 1'b1;
      bus.CFG_MASK   = 4'hF;

      // all four continuously valid: order 0,1,2,3,0
      @(posedge clk);
      #1;
      src_frame(0, 16'h1000, 8, 1'b0);
      src_frame(1, 16'h2000, 4, 1'b0);
      src_frame(2, 16'h3000, 4, 1'b0);
      src_frame(3, 16'h4000, 4, 1'b1);
      exp_frame(0, 16'h1000, 1'b0);
      exp_frame(1, 16'h2000, 1'b0);
      exp_frame(2, 16'h3000, 1'b0);
      exp_frame(3, 16'h4000, 1'b1);
      exp_frame(0, 16'h1004, 1'b0);
      cw_q.push_back(2'd0);
      cw_q.push_back(2'd1);
      cw_q.push_back(2'd2);
      cw_q.push_back(2'd3);
      cw_q.push_back(2'd0);
      wait_idle("rr_all4", 300);

      // source 1 alone, with encoder backpressure mid-frame
      @(posedge clk);
      #1;
      srcq[1].push_back(sbeat_t'{d: 16'h1111, fl: 1'b0, sl: 1'b0});
      srcq[1].push_back(sbeat_t'{d: 16'h2222, fl: 1'b0, sl: 1'b0});
      srcq[1].push_back(sbeat_t'{d: 16'h3333, fl: 1'b0, sl: 1'b0});
      srcq[1].push_back(sbeat_t'{d: 16'h4444, fl: 1'b0, sl: 1'b0});
      exp_beat(16'h1111, 1'b0, 4'b0010);
      exp_beat(16'h2222, 1'b0, 4'b0010);
      exp_beat(16'h3333, 1'b0, 4'b0010);
      exp_beat(16'h4444, 1'b1, 4'b0010);
      cw_q.push_back(2'd1);
      @(negedge clk);
      chk("grant_latency_idle", 32'(bus.BUSY), 0);
      @(negedge clk);
      chk("grant_latency_ready", 32'(bus.S_READY), 32'h2);
      @(posedge clk);
      #1 bus.ENC_READY = 1'b0;
      @(negedge clk);
      chk("stall_s_ready", 32'(bus.S_READY), 0);
      chk("stall_in_valid", 32'(bus.ENC_IN_VALID), 1);
      repeat (2) @(posedge clk);
      #1 bus.ENC_READY = 1'b1;
      wait_idle("src1_only", 100);

      // early frame end from source 2, padded with zero beats
      @(posedge clk);
      #1;
      srcq[2].push_back(sbeat_t'{d: 16'hAAAA, fl: 1'b0, sl: 1'b0});
      srcq[2].push_back(sbeat_t'{d: 16'hBBBB, fl: 1'b1, sl: 1'b0});
      exp_beat(16'hAAAA, 1'b0, 4'b0100);
      exp_beat(16'hBBBB, 1'b0, 4'b0100);
      exp_beat(16'h0000, 1'b0, 4'b0000);
      exp_beat(16'h0000, 1'b1, 4'b0000);
      cw_q.push_back(2'd2);
      wait_idle("flast_pad", 100);

      // source 0 stalls after one beat: timeout flush
      @(posedge clk);
      #1;
      exp_tuser = 1;
      srcq[0].push_back(sbeat_t'{d: 16'h5555, fl: 1'b0, sl: 1'b0});
      exp_beat(16'h5555, 1'b0, 4'b0001);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.ENC_IN_VALID && bus.ENC_READY &&
                   bus.S_READY == 4'b0001) && n < 20);
      chk("tmo_first_beat_seen", 32'(n < 20), 1);
      n = 0;
      @(negedge clk);
      while (!bus.ENC_TUSER && n < 30) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_idle_cycles", 32'(n), 8);
      @(negedge clk);
      chk("tmo_tuser_one_cycle", 32'(bus.ENC_TUSER), 0);
      chk("tmo_back_idle", 32'(bus.BUSY), 0);
      chk("tmo_stat", 32'(bus.STAT_TIMEOUTS), 1);
      @(posedge clk);
      #1;
      src_frame(0, 16'h6000, 4, 1'b0);
      src_frame(1, 16'h7000, 4, 1'b0);
      exp_frame(1, 16'h7000, 1'b0);
      exp_frame(0, 16'h6000, 1'b0);
      cw_q.push_back(2'd1);
      cw_q.push_back(2'd0);
      wait_idle("tmo_next_grant", 150);

      // mask source 3 mid-frame: frame completes, no further grant
      @(posedge clk);
      #1;
      src_frame(3, 16'h8000, 8, 1'b0);
      exp_frame(3, 16'h8000, 1'b0);
      cw_q.push_back(2'd3);
      n = 0;
      while (srcq[3].size() > 6 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("mask_mid_frame_reached", 32'(n < 50), 1);
      bus.CFG_MASK = 4'b0111;
      src_frame(1, 16'h9000, 4, 1'b0);
      exp_frame(1, 16'h9000, 1'b0);
      cw_q.push_back(2'd1);
      wait_idle("mask_change", 150);
      repeat (10) @(negedge clk);
      chk("mask_no_regrant_busy", 32'(bus.BUSY), 0);
      chk("mask_src3_pending", 32'(srcq[3].size()), 4);
      chk("mask_src3_valid", 32'(bus.S_VALID[3]), 1);

      // asynchronous reset while padding, then grant restarts at source 0
      @(posedge clk);
      #1;
      srcq[3].delete();
      bus.CFG_MASK = 4'hF;
      srcq[1].push_back(sbeat_t'{d: 16'h7777, fl: 1'b1, sl: 1'b0});
      exp_beat(16'h7777, 1'b0, 4'b0010);
      exp_beat(16'h0000, 1'b0, 4'b0000);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.ENC_IN_VALID && bus.S_READY == 4'b0000 && bus.BUSY)
                 && n < 30);
      chk("pad_reached", 32'(n < 30), 1);
      #2 rst_n = 1'b0;
      #1 check_zero("rst_pad");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      src_frame(2, 16'hB000, 4, 1'b0);
      src_frame(0, 16'hC000, 4, 1'b0);
      exp_frame(0, 16'hC000, 1'b0);
      exp_frame(2, 16'hB000, 1'b0);
      cw_q.push_back(2'd0);
      cw_q.push_back(2'd2);
      wait_idle("post_reset_grant", 150);
      chk("tuser_all_seen", 32'(exp_tuser), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
